// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared width default, packer state encoding and keep-mask helper
//            for the async_fifo read-side packer.
// Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

   localparam int DATAWIDTH_DEF = 8;
   localparam int PACK_MAX      = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } pack_state_e;

   // Low 'cnt' bits set; callers narrow the result to their own PACK width.
   function automatic logic [PACK_MAX-1:0] keep_mask(input int cnt);
      logic [PACK_MAX-1:0] m;
      m = '0;
      for (int k = 0; k < PACK_MAX; k++) begin
         if (k < cnt) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_packer
// Purpose  : Drains async_fifo entries and packs PACK of them little-endian
//            into a valid/ready word; idle partial words flush with a keep mask.
// Revision : 1.0  initial release
// ============================================================================
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int PACK      = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                      clk_rd,
   input  logic                      rrst,
   input  logic                      I_empty,
   output logic                      O_rden,
   input  logic [DATAWIDTH-1:0]      I_fifo_data,
   output logic [DATAWIDTH*PACK-1:0] O_word,
   output logic [PACK-1:0]           O_keep,
   output logic                      O_valid,
   input  logic                      I_ready
);

   localparam int              CW       = $clog2(PACK + 1);
   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam int              WW       = DATAWIDTH * PACK;
   localparam logic [CW:0]     PACK_EXT = (CW + 1)'(PACK);
   localparam logic [CW-1:0]   PACK_CNT = CW'(PACK);
   localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]   TO_FULL  = TW'(TIMEOUT);

   pack_state_e          state;
   logic [CW-1:0]        count;
   logic                 pending;
   logic [TW-1:0]        idle_cnt;
   logic                 flush_req;
   logic [DATAWIDTH-1:0] slots [PACK];

   logic                 out_free;
   logic [CW:0]          inflight;
   logic [WW-1:0]        full_word;
   logic [WW-1:0]        part_word;

   assign out_free = !O_valid || I_ready;
   assign inflight = {1'b0, count} + {{CW{1'b0}}, pending};

   // Reads in flight count against capacity so the last slot is never overrun.
   assign O_rden = !rrst && !I_empty && (inflight < PACK_EXT) && !flush_req;

   always_comb begin
      full_word = '0;
      part_word = '0;
      for (int k = 0; k < PACK; k++) begin
         if ((k == PACK - 1) && pending)
            full_word[k*DATAWIDTH +: DATAWIDTH] = I_fifo_data;
         else
            full_word[k*DATAWIDTH +: DATAWIDTH] = slots[k];
         if (k < int'(count))
            part_word[k*DATAWIDTH +: DATAWIDTH] = slots[k];
      end
   end

   always_ff @(posedge clk_rd) begin
      if (rrst) begin
         state     <= IDLE;
         count     <= '0;
         pending   <= 1'b0;
         idle_cnt  <= '0;
         flush_req <= 1'b0;
         O_valid   <= 1'b0;
         O_word    <= '0;
         O_keep    <= '0;
         for (int k = 0; k < PACK; k++) slots[k] <= '0;
      end else begin
         pending <= O_rden;
         if (O_valid && I_ready) O_valid <= 1'b0;

         if (pending) begin
            for (int k = 0; k < PACK; k++) begin
               if (int'(count) == k) slots[k] <= I_fifo_data;
            end
            idle_cnt <= '0;
            if (int'(count) == PACK - 1) begin
               if (out_free) begin
                  O_word  <= full_word;
                  O_keep  <= '1;
                  O_valid <= 1'b1;
                  count   <= '0;
                  state   <= IDLE;
               end else begin
                  count <= PACK_CNT;
                  state <= HOLD;
               end
            end else begin
               count <= count + 1'b1;
               state <= FILL;
            end
         end else if (state == HOLD) begin
            if (out_free) begin
               O_word  <= full_word;
               O_keep  <= '1;
               O_valid <= 1'b1;
               count   <= '0;
               state   <= IDLE;
            end
         end else if (state == FLUSH) begin
            if (out_free) begin
               O_word    <= part_word;
               O_keep    <= PACK'(keep_mask(int'(count)));
               O_valid   <= 1'b1;
               count     <= '0;
               idle_cnt  <= '0;
               flush_req <= 1'b0;
               state     <= IDLE;
            end
         end else if ((state == FILL) && I_empty) begin
            // The final idle cycle raises the flush and blocks further reads.
            if (idle_cnt == TO_LAST) begin
               idle_cnt  <= TO_FULL;
               flush_req <= 1'b1;
               state     <= FLUSH;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of async_fifo in the clk_rd domain.
- Drains DATAWIDTH-bit entries through the FIFO's I_rden/O_data_out/empty interface.
- Packs PACK consecutive entries little-endian into one wide word and presents it on a valid/ready stream to the downstream datapath.
- A partial word is flushed with a keep mask after TIMEOUT idle cycles, so trailing bytes never stall.

Parameters:
- DATAWIDTH, 8: FIFO entry width; must match async_fifo DATAWIDTH.
- PACK, 4: entries per output word; legal range 2..8.
- TIMEOUT, 16: idle cycles before a partial word is flushed; legal range 2..255.

Ports:
- clk_rd  in  1  read-domain clock; same clock as async_fifo clk_rd.
- rrst  in  1  synchronous, active-high reset.
- I_empty  in  1  async_fifo empty flag.
- O_rden  out  1  read enable to async_fifo I_rden.
- I_fifo_data  in  DATAWIDTH  async_fifo O_data_out.
- O_word  out  DATAWIDTH*PACK  packed output word; entry k occupies bits [k*DATAWIDTH +: DATAWIDTH].
- O_keep  out  PACK  per-entry valid mask for O_word.
- O_valid  out  1  output word valid.
- I_ready  in  1  downstream accept.

Behaviour:
- Interface decided: one clock (clk_rd); reset rrst is synchronous and active-high.
- Reset values: O_rden=0, O_valid=0, O_word=0, O_keep=0. Assembly count, pending flag and idle counter are cleared.
- Reset mid-operation discards the partial word and any word held on the output without signalling. A read in flight at reset is dropped.
- FIFO read latency:
  - I_fifo_data is valid exactly 1 cycle after a cycle with O_rden=1.
  - A pending flag marks that cycle.
- Read issue: O_rden = !I_empty && (count + pending) < PACK && !flush_req.
  - O_rden is combinational from registered state and I_empty.
  - O_rden is never asserted while I_empty=1.
- Capture: on a cycle with pending=1, the entry is written to slot[count] and count increments.
- Completion: if the captured entry fills slot PACK-1 and the output is free (!O_valid || I_ready):
  - O_word is loaded with all slots including this entry, O_keep becomes all-ones, O_valid=1.
  - count returns to 0 on the same edge.
  - If the output is not free, count holds at PACK (state HOLD) and no reads are issued until the transfer happens.
- Handshake:
  - A transfer occurs when O_valid && I_ready.
  - O_word and O_keep stay stable while O_valid && !I_ready.
  - On transfer with no new word ready, O_valid drops next cycle.
  - A new word may load on the same edge as a transfer, giving back-to-back valid.
- Throughput: sustained 4 entries per 5 cycles at PACK=4, with one bubble per word.
- States:
  - IDLE: count=0.
  - FILL: 0<count<PACK.
  - HOLD: count=PACK, waiting for the output.
  - FLUSH: flush_req set.
  - Transitions: IDLE→FILL on first capture; FILL→IDLE on completion with output free; FILL→HOLD on completion with output busy; HOLD→IDLE on transfer; FILL→FLUSH on timeout; FLUSH→IDLE when the partial word loads.
- Timeout:
  - The idle counter increments while FILL && !pending && I_empty, and clears on every capture.
  - On reaching TIMEOUT, flush_req is set and O_rden is blocked.
  - When the output is free, O_word loads the slots (unused slots 0) and O_keep = (1<<count)-1.
  - count returns to 0 and flush_req clears.
- Simultaneous events:
  - I_empty deasserting in the same cycle the timeout hits: the flush wins, and reading resumes after the flush.
  - A capture on the timeout cycle cannot occur, because the counter requires !pending.
- Width rules:
  - count and the idle counter are sized with $clog2(PACK+1) and $clog2(TIMEOUT+1) bits respectively.
  - There is no arithmetic wrap: saturation is impossible by construction.

Decomposition:
- Shared package fifo_pkg holds:
  - DATAWIDTH default, shared with async_fifo.
  - The state encoding enum {IDLE, FILL, HOLD, FLUSH}.
  - A function keep_mask(count) returning the PACK-bit mask.
- No sub-module: a single flat module. The output register and handshake are simple enough to stay inline.

Test Plan:
1. Reset then feed: FIFO preloaded with 0x11,0x22,0x33,0x44, I_ready=1 -> O_rden never high while I_empty=1; O_valid with O_word=0x44332211, O_keep=4'hF.
2. Backpressure: 8 entries 0x01..0x08, I_ready=0 -> first word 0x04030201 held stable; O_rden stops at count=4 (HOLD); raise I_ready -> 0x04030201 transfers, then 0x08070605 follows.
3. Timeout flush: 3 entries 0x7E,0x7E,0x7E then FIFO empty -> exactly TIMEOUT=16 idle cycles later O_word=0x007E7E7E, O_keep=4'h7.
4. Streaming: 40 entries 0x00..0x27 continuously available, I_ready=1 -> 10 words, correct order, no duplicate or dropped entries, at most 1 bubble per word.
5. Reset mid-fill: 2 entries captured, rrst pulsed for 1 cycle -> O_valid=0; next word starts at slot 0 with no stale data.
6. Read-latency check: single entry 0x56 with I_empty toggling every cycle -> pending correctly tracks the 1-cycle latency; flush gives O_word=0x00000056, O_keep=4'h1.
